// File: rtl/plab4_net_ter_eject_demux_pkg.sv
// Message-format helpers shared by the terminal ejection demux and its queues.
// Optional stats counters are enabled with PLAB4_NET_EJECT_STATS_EN.
`ifndef VC_NET_MSG_NBITS
`define VC_NET_MSG_NBITS(p,o,s) ((p)+(o)+2*(s))
`endif

package plab4_net_ter_eject_demux_pkg;

  localparam int unsigned c_stat_nbits = 16;
  localparam logic [c_stat_nbits-1:0] c_stat_max = 16'hFFFF;

  // Width of the buffered body {src, opaque, payload}; dest is stripped on ejection.
  function automatic int unsigned eject_body_nbits(input int unsigned p,
                                                   input int unsigned o,
                                                   input int unsigned s);
    return p + o + s;
  endfunction

endpackage

// File: rtl/plab4_net_ter_eject_queue.sv
// Circular-buffer FIFO with val/rdy on both sides; one instance per domain.
// enq_rdy_o is !full and deq_val_o is !empty; no bypass and no pipelined enqueue.
module plab4_net_ter_eject_queue
  import plab4_net_ter_eject_demux_pkg::*;
#(
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned p_data_nbits  = 38
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_val_i,
  output logic                    enq_rdy_o,
  input  logic [p_data_nbits-1:0] enq_data_i,
  output logic                    deq_val_o,
  input  logic                    deq_rdy_i,
  output logic [p_data_nbits-1:0] deq_data_o
);

  localparam int unsigned c_ptr_nbits = $clog2(p_num_entries);
  localparam int unsigned c_cnt_nbits = c_ptr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_num_entries);

  logic [c_ptr_nbits-1:0]  enq_ptr_q, enq_ptr_d;
  logic [c_ptr_nbits-1:0]  deq_ptr_q, deq_ptr_d;
  logic [c_cnt_nbits-1:0]  count_q, count_d;
  logic [p_data_nbits-1:0] mem_q [p_num_entries];
  logic                    do_enq, do_deq;

  assign enq_rdy_o  = (count_q != c_cnt_full);
  assign deq_val_o  = (count_q != '0);
  assign deq_data_o = mem_q[deq_ptr_q];
  assign do_enq     = enq_val_i && enq_rdy_o;
  assign do_deq     = deq_val_o && deq_rdy_i;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq) enq_ptr_d = enq_ptr_q + 1'b1;
    if (do_deq) deq_ptr_d = deq_ptr_q + 1'b1;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[enq_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/plab4_net_ter_eject_demux.sv
// Terminal ejection receiver: dest check, per-domain queueing, misroute pulses, stats.
// Define PLAB4_NET_EJECT_STATS_EN to build the delivery counters; otherwise they read 0.
module plab4_net_ter_eject_demux
  import plab4_net_ter_eject_demux_pkg::*;
#(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_entries   = 2,
  localparam int unsigned c_net_msg_nbits =
    `VC_NET_MSG_NBITS(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [c_net_msg_nbits-1:0] in_msg,
  input  logic                       in_domain,
  output logic                       out_val_d0,
  input  logic                       out_rdy_d0,
  output logic [p_payload_nbits-1:0] out_payload_d0,
  output logic [p_srcdest_nbits-1:0] out_src_d0,
  output logic [p_opaque_nbits-1:0]  out_opaque_d0,
  output logic                       out_val_d1,
  input  logic                       out_rdy_d1,
  output logic [p_payload_nbits-1:0] out_payload_d1,
  output logic [p_srcdest_nbits-1:0] out_src_d1,
  output logic [p_opaque_nbits-1:0]  out_opaque_d1,
  output logic                       misroute_d0,
  output logic                       misroute_d1,
  output logic [c_stat_nbits-1:0]    count_d0,
  output logic [c_stat_nbits-1:0]    count_d1
);

  localparam int unsigned c_body_nbits =
    eject_body_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);
  localparam logic [p_srcdest_nbits-1:0] c_my_id = p_srcdest_nbits'(p_router_id);

  logic [p_srcdest_nbits-1:0] in_dest;
  logic [c_body_nbits-1:0]    in_body;
  logic [c_body_nbits-1:0]    deq_data_d0, deq_data_d1;
  logic enq_rdy_d0, enq_rdy_d1;
  logic xfer, dest_ok;
  logic misroute_d0_q, misroute_d0_d, misroute_d1_q, misroute_d1_d;

  assign in_dest = in_msg[c_net_msg_nbits-1 -: p_srcdest_nbits];
  assign in_body = in_msg[c_body_nbits-1:0];
  assign dest_ok = (in_dest == c_my_id);

  // Ready depends only on the selected domain's full flag, never on in_val or a same-cycle dequeue.
  assign in_rdy = in_domain ? enq_rdy_d1 : enq_rdy_d0;
  assign xfer   = in_val && in_rdy;

  plab4_net_ter_eject_queue #(
    .p_num_entries (p_num_entries),
    .p_data_nbits  (c_body_nbits)
  ) u_queue_d0 (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (xfer && !in_domain && dest_ok),
    .enq_rdy_o  (enq_rdy_d0),
    .enq_data_i (in_body),
    .deq_val_o  (out_val_d0),
    .deq_rdy_i  (out_rdy_d0),
    .deq_data_o (deq_data_d0)
  );

  plab4_net_ter_eject_queue #(
    .p_num_entries (p_num_entries),
    .p_data_nbits  (c_body_nbits)
  ) u_queue_d1 (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (xfer && in_domain && dest_ok),
    .enq_rdy_o  (enq_rdy_d1),
    .enq_data_i (in_body),
    .deq_val_o  (out_val_d1),
    .deq_rdy_i  (out_rdy_d1),
    .deq_data_o (deq_data_d1)
  );

  assign {out_src_d0, out_opaque_d0, out_payload_d0} = deq_data_d0;
  assign {out_src_d1, out_opaque_d1, out_payload_d1} = deq_data_d1;

  assign misroute_d0_d = xfer && !in_domain && !dest_ok;
  assign misroute_d1_d = xfer && in_domain && !dest_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_d0_q <= 1'b0;
      misroute_d1_q <= 1'b0;
    end else begin
      misroute_d0_q <= misroute_d0_d;
      misroute_d1_q <= misroute_d1_d;
    end
  end

  assign misroute_d0 = misroute_d0_q;
  assign misroute_d1 = misroute_d1_q;

`ifdef PLAB4_NET_EJECT_STATS_EN
  logic [c_stat_nbits-1:0] count_d0_q, count_d0_d, count_d1_q, count_d1_d;

  // Saturating delivery counters.
  always_comb begin
    count_d0_d = count_d0_q;
    count_d1_d = count_d1_q;
    if (out_val_d0 && out_rdy_d0 && (count_d0_q != c_stat_max)) count_d0_d = count_d0_q + 1'b1;
    if (out_val_d1 && out_rdy_d1 && (count_d1_q != c_stat_max)) count_d1_d = count_d1_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_d0_q <= '0;
      count_d1_q <= '0;
    end else begin
      count_d0_q <= count_d0_d;
      count_d1_q <= count_d1_d;
    end
  end

  assign count_d0 = count_d0_q;
  assign count_d1 = count_d1_q;
`else
  assign count_d0 = '0;
  assign count_d1 = '0;
`endif

endmodule
